// File: rtl/data_mem_pkg.sv
// Shared constants and request encoding for the data-memory responder.
package data_mem_pkg;

  localparam int DMEM_WORD_BYTES       = 4;
  localparam int DMEM_MAX_READ_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } req_kind_e;

endpackage

// File: rtl/data_mem_read_pipe.sv
// Fixed-latency read return pipeline: a LATENCY-deep shift register of {valid, data}.
module data_mem_read_pipe #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [31:0]        data_q [LATENCY];
  logic [31:0]        data_d [LATENCY];

  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= data_d[i];
    end
  end

  // Gate data so the output reads zero whenever no strobe is present.
  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : 32'd0;

endmodule

// File: rtl/data_mem.sv
// Data-memory responder for the MEM stage: word array, legality check, fault
// reporting, and a fixed-latency read return path.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_read_addr,
  input  logic [31:0] data_mem_write_addr,
  input  logic [31:0] data_mem_write_data,
  output logic [31:0] data_mem_read_data,
  output logic        data_mem_read_valid,
  output logic        data_mem_fault,
  output logic [31:0] data_mem_fault_addr
);

  localparam int BYTE_BITS = $clog2(DMEM_WORD_BYTES);
  localparam int IDX_BITS  = $clog2(DEPTH_WORDS);

  req_kind_e             req_kind;
  logic [31:0]           req_addr;
  logic                  req_legal;
  logic [IDX_BITS-1:0]   req_idx;

  logic [31:0]           mem [DEPTH_WORDS];

  logic                  fault_q, fault_d;
  logic [31:0]           fault_addr_q, fault_addr_d;
  logic                  rd_valid_d;
  logic [31:0]           rd_data_d;

  // Stores arrive with read_enable also high, so write wins the decode.
  always_comb begin
    req_kind = IDLE;
    req_addr = data_mem_read_addr;
    if (data_mem_write_enable) begin
      req_kind = WRITE;
      req_addr = data_mem_write_addr;
    end else if (data_mem_read_enable) begin
      req_kind = READ;
    end

    req_idx   = req_addr[IDX_BITS+BYTE_BITS-1:BYTE_BITS];
    req_legal = (req_addr[BYTE_BITS-1:0] == '0) &&
                ((req_addr >> (IDX_BITS + BYTE_BITS)) == 32'd0);

    fault_d      = (req_kind != IDLE) && !req_legal;
    fault_addr_d = fault_d ? req_addr : fault_addr_q;

    // Illegal reads still occupy their return slot, carrying zero.
    rd_valid_d = (req_kind == READ);
    rd_data_d  = (rd_valid_d && req_legal) ? mem[req_idx] : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (req_kind == WRITE && req_legal) mem[req_idx] <= data_mem_write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  data_mem_read_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_valid_d),
    .in_data   (rd_data_d),
    .out_valid (data_mem_read_valid),
    .out_data  (data_mem_read_data)
  );

  assign data_mem_fault      = fault_q;
  assign data_mem_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: directed requests push expected read returns
// and fault events; a negedge monitor pops and compares them as they appear.
module tb_data_mem;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0, we = 1'b0;
  logic [31:0] raddr = '0, waddr = '0, wdata = '0;
  logic [31:0] rdata, faddr;
  logic        rvalid, fault;

  data_mem #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .data_mem_read_enable  (re),
    .data_mem_write_enable (we),
    .data_mem_read_addr    (raddr),
    .data_mem_write_addr   (waddr),
    .data_mem_write_data   (wdata),
    .data_mem_read_data    (rdata),
    .data_mem_read_valid   (rvalid),
    .data_mem_fault        (fault),
    .data_mem_fault_addr   (faddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t rq[$];
  exp_t fq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic chk_zero = 1'b0;
  logic chk_empty = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (chk_zero) begin
      n_tests++;
      if (rvalid !== 1'b0 || rdata !== 32'd0 || fault !== 1'b0 || faddr !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got valid=%b data=%h fault=%b faddr=%h, need all 0",
                 rvalid, rdata, fault, faddr);
      end
    end
    if (chk_empty) begin
      n_tests++;
      if (rq.size() != 0 || fq.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d reads and %0d faults outstanding, need 0 and 0",
                 rq.size(), fq.size());
      end
    end
    if (rst_n) begin
      if (rq.size() > 0 && rq[0].due < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL read_missing: got no read_valid by cycle %0d, need one at cycle %0d",
                 cyc, rq[0].due);
        void'(rq.pop_front());
      end
      if (fq.size() > 0 && fq[0].due < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL fault_missing: got no fault by cycle %0d, need one at cycle %0d (addr %h)",
                 cyc, fq[0].due, fq[0].val);
        void'(fq.pop_front());
      end
      if (rvalid === 1'b1) begin
        n_tests++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL read_unexpected: got read_valid data=%h at cycle %0d, need none", rdata, cyc);
        end else begin
          e = rq.pop_front();
          if (rdata !== e.val || cyc != e.due) begin
            n_fail++;
            $display("FAIL read_data: got %h at cycle %0d, need %h at cycle %0d",
                     rdata, cyc, e.val, e.due);
          end
        end
      end
      if (fault === 1'b1) begin
        n_tests++;
        if (fq.size() == 0) begin
          n_fail++;
          $display("FAIL fault_unexpected: got fault addr=%h at cycle %0d, need none", faddr, cyc);
        end else begin
          e = fq.pop_front();
          if (faddr !== e.val || cyc != e.due) begin
            n_fail++;
            $display("FAIL fault_addr: got %h at cycle %0d, need %h at cycle %0d",
                     faddr, cyc, e.val, e.due);
          end
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit flt);
    @(posedge clk); #1;
    we = 1'b1; re = 1'b0; waddr = a; wdata = d;
    if (flt) fq.push_back('{a, cyc + 1});
  endtask

  // Store as the MEM stage issues it: both enables high, no read return.
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    we = 1'b1; re = 1'b1; waddr = a; raddr = a; wdata = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input bit flt);
    @(posedge clk); #1;
    we = 1'b0; re = 1'b1; raddr = a;
    rq.push_back('{exp_d, cyc + LAT});
    if (flt) fq.push_back('{a, cyc + 1});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero = 1'b1;
    @(posedge clk); #1 chk_zero = 1'b0;
    rst_n = 1'b1;

    // Write then read next cycle.
    wr(32'h10, 32'hDEADBEEF, 0);
    rd(32'h10, 32'hDEADBEEF, 0);
    idle();

    // Store with read_enable high produces no return.
    st(32'h20, 32'h12345678);
    rd(32'h20, 32'h12345678, 0);

    // Faults: misaligned read, out-of-range write leaves word 0 intact.
    wr(32'h0, 32'hA5A5A5A5, 0);
    rd(32'h13, 32'h0, 1);
    wr(32'h100, 32'hFFFFFFFF, 1);
    rd(32'h0, 32'hA5A5A5A5, 0);
    idle();

    // Back-to-back faults, fault_addr tracks the latest.
    wr(32'h102, 32'h1, 1);
    rd(32'h200, 32'h0, 1);
    rd(32'h80000000, 32'h0, 1);

    // Streaming reads return in order, one per cycle.
    wr(32'h0, 32'd1, 0);
    wr(32'h4, 32'd2, 0);
    wr(32'h8, 32'd3, 0);
    wr(32'hC, 32'd4, 0);
    rd(32'h0, 32'd1, 0);
    rd(32'h4, 32'd2, 0);
    rd(32'h8, 32'd3, 0);
    rd(32'hC, 32'd4, 0);

    // Read-before-write ordering.
    wr(32'h40, 32'd5, 0);
    rd(32'h40, 32'd5, 0);
    wr(32'h40, 32'd9, 0);
    rd(32'h40, 32'd9, 0);

    // Last legal word and first illegal word.
    wr(32'hFC, 32'h00000077, 0);
    rd(32'hFC, 32'h00000077, 0);
    rd(32'h100, 32'h0, 1);
    idle();

    repeat (LAT + 3) idle();
    #1 chk_empty = 1'b1;
    @(posedge clk); #1 chk_empty = 1'b0;

    // Reset mid-flight drops the outstanding read.
    @(posedge clk); #1;
    re = 1'b1; raddr = 32'h10;
    @(posedge clk); #1;
    re = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; chk_zero = 1'b1;
    @(posedge clk); #1 chk_zero = 1'b0;
    repeat (LAT + 2) idle();
    #1 chk_zero = 1'b1;
    @(posedge clk); #1 chk_zero = 1'b0;
    chk_empty = 1'b1;
    @(posedge clk); #1 chk_empty = 1'b0;
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
